// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Two-port round-robin arbiter in front of a single-port synchronous RAM,
// with a built-in sequencer that clears the whole array to zero.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req0/1, we0/1            per-port request and write select
//   addr0/1, wdata0/1        per-port address and write data
//   gnt0/1                   combinational grant (req & gnt at an edge = accept)
//   rvalid0/1                one-cycle read-data-valid strobe per port
//   rdata                    shared read data (straight from ram_dout)
//   clr_start                pulse: start clearing the array
//   clr_busy, clr_done       clear in progress / one-cycle completion pulse
//   ram_ce, ram_wr           registered RAM chip-enable / write-enable
//   ram_addr, ram_din        registered RAM address / write data
//   ram_dout                 RAM read data, one cycle after a read is sampled
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_ce,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_prio;      // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic [AW-1:0] r_cnt;       // clear address counter
    logic          r_tag_v;     // tag stage 1: read issued to RAM this cycle
    logic          r_tag_port;  // tag stage 1: which port owns that read
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          r_clr_busy;
    logic          r_clr_done;
    logic          r_ram_ce;
    logic          r_ram_wr;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;

    logic          w_arb_ok;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_acc;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // Grants only exist in ARB; a clr_start in the same cycle takes precedence
    // so the pending request stays pending until the clear has finished.
    assign w_arb_ok = !rst && (r_state == ARB) && !clr_start;
    assign w_gnt0   = w_arb_ok && req0 && (!req1 || !r_prio);
    assign w_gnt1   = w_arb_ok && req1 && (!req0 ||  r_prio);
    assign w_acc    = w_gnt0 || w_gnt1;

    // NOTE: combinational selection is written as continuous assigns so every
    // path has a value and no latch can be inferred.
    assign w_sel_we    = w_gnt1 ? we1    : we0;
    assign w_sel_addr  = w_gnt1 ? addr1  : addr0;
    assign w_sel_wdata = w_gnt1 ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB;
            r_prio     <= 1'b0;
            r_cnt      <= '0;
            r_tag_v    <= 1'b0;
            r_tag_port <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
            r_ram_ce   <= 1'b0;
            r_ram_wr   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // below sees the pre-edge value of every other register.
            // Tag stage 2: the RAM samples the read at this edge, so its data
            // is on ram_dout for exactly the cycle this strobe is high.
            r_rvalid0  <= r_tag_v && !r_tag_port;
            r_rvalid1  <= r_tag_v &&  r_tag_port;
            r_tag_v    <= 1'b0;
            r_clr_done <= 1'b0;

            case (r_state)
                ARB: begin
                    if (clr_start) begin
                        r_state    <= CLEAR;
                        r_clr_busy <= 1'b1;
                        r_cnt      <= '0;
                        r_ram_ce   <= 1'b0;
                        r_ram_wr   <= 1'b0;
                    end else if (w_acc) begin
                        r_ram_ce   <= 1'b1;
                        r_ram_wr   <= w_sel_we;
                        r_ram_addr <= w_sel_addr;
                        r_ram_din  <= w_sel_wdata;
                        // Favour the other port next time both request.
                        r_prio     <= w_gnt0;
                        r_tag_v    <= !w_sel_we;
                        r_tag_port <= w_gnt1;
                    end else begin
                        r_ram_ce   <= 1'b0;
                        r_ram_wr   <= 1'b0;
                    end
                end

                CLEAR: begin
                    // clr_start is not looked at here, so a pulse during the
                    // sequence neither restarts nor extends it.
                    r_ram_ce   <= 1'b1;
                    r_ram_wr   <= 1'b1;
                    r_ram_addr <= r_cnt;
                    r_ram_din  <= '0;
                    r_cnt      <= r_cnt + 1'b1;  // wraps to 0 after the top address
                    if (r_cnt == {AW{1'b1}}) begin
                        r_state    <= ARB;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                    end
                end

                default: r_state <= ARB;
            endcase
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = ram_dout;
    assign clr_busy = r_clr_busy;
    assign clr_done = r_clr_done;
    assign ram_ce   = r_ram_ce;
    assign ram_wr   = r_ram_wr;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;

endmodule
